register_load_arbiter: RTL and testbench
========================================

REGISTER_LOAD_ARBITER -- requirements
Module: register_load_arbiter

Interface
REQ-001 Parameter N, default 8: data width of each requester payload and of the shared bus.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately, independent of clk.
REQ-004 hold  input  1  when 1, blocks new grants; a transfer already in progress still completes.
REQ-005 req  input  4  per-requester request; bit i high = requester i wants one register load.
REQ-006 dest  input  4x2  per-requester target register index, 0..3.
REQ-007 data  input  4xN  per-requester payload.
REQ-008 bus_data  output  N  registered shared bus value presented to the target registers.
REQ-009 load_en  output  4  registered one-hot load strobe, one bit per target register.
REQ-010 ack  output  4  registered one-hot acknowledge to the served requester.
REQ-011 grant_id  output  2  registered index of the requester currently served.
REQ-012 busy  output  1  high while in LOAD state.

Function
REQ-013 The FSM SHALL have two states, IDLE and LOAD, and reset into IDLE.
REQ-014 In IDLE, with hold=0 and req!=0, the FSM SHALL select winner g by round-robin and move to LOAD on the next edge.
REQ-015 Round-robin: search starts at pointer p and proceeds p, p+1, ... mod 4; the first set req bit wins.
REQ-016 Pointer p SHALL reset to 0 and update to (g+1) mod 4 on each IDLE->LOAD edge.
REQ-017 On the IDLE->LOAD edge, data[g] SHALL be captured into bus_data, dest[g] into a target register, and g into grant_id.
REQ-018 In LOAD (exactly one cycle): load_en = one-hot of the captured dest; ack = one-hot of g; busy = 1.
REQ-019 LOAD SHALL always return to IDLE on the next edge, regardless of hold or req.
REQ-020 In IDLE, load_en, ack and busy SHALL be 0; bus_data and grant_id hold their last values.
REQ-021 Throughput: at most one transfer per 2 cycles; grant latency is 1 cycle from the sampled request.
REQ-022 Requester contract: keep req, dest and data stable until ack is sampled high, then drop req on that edge; req still high in the following IDLE cycle is treated as a new request.
REQ-023 req, dest and data changes during LOAD SHALL NOT affect the in-flight transfer.
REQ-024 hold=1 in IDLE: no grant; the pointer is unchanged. hold=1 in LOAD has no effect.
REQ-025 Simultaneous requests SHALL be served one per transfer, in round-robin order; no requester starves while its req stays high.
REQ-026 req=0 in IDLE: remain in IDLE; no outputs asserted.
REQ-027 Multiple requesters with the same dest value are legal; each is served in turn, and the last write wins.

Reset
REQ-028 While reset=0: state=IDLE, p=0, bus_data=0, load_en=0, ack=0, grant_id=0, busy=0.
REQ-029 Reset asserted mid-LOAD SHALL drop load_en and ack immediately (asynchronously); the transfer is lost and no ack follows after release.
REQ-030 After reset release, the first grant SHALL be evaluable on the first rising edge.

Verification
REQ-031 Single request: req=0001, dest0=2, data0=0xA5 -> next cycle load_en=0100, bus_data=0xA5, ack=0001, grant_id=0; then IDLE.
REQ-032 All-request fairness: req=1111 held, each requester dropping req on its own ack -> grant order 0,1,2,3, with transfers on every second cycle.
REQ-033 Pointer wrap: p=3 with req=1001 -> requester 3 granted first, then 0; p becomes 1.
REQ-034 Hold: hold=1 with req=0010 for 5 cycles -> no ack and busy=0; hold drops -> ack=0010 one cycle later.
REQ-035 Reset mid-LOAD: assert reset during LOAD -> load_en=0 and ack=0 without waiting for an edge; after release, outputs=0 and p=0.
REQ-036 In-flight stability: change data0 from 0x11 to 0xFF during LOAD -> bus_data stays 0x11 for that transfer.

Source files
------------

// File: rtl/register_load_arbiter_if.sv
// register_load_arbiter_if
//   Bundles the requester-side inputs and the shared register-bus outputs of
//   register_load_arbiter.
//   Requester side (driven by the master modport):
//     hold      - block new grants
//     req[4]    - per-requester load request
//     dest[4]   - per-requester target register index (0..3)
//     data[4]   - per-requester payload, N bits
//   Bus side (driven by the arbiter through the slave modport):
//     bus_data  - captured payload of the current or last transfer
//     load_en   - one-hot register load strobe
//     ack       - one-hot acknowledge to the served requester
//     grant_id  - index of the served requester
//     busy      - high while a transfer is in LOAD
interface register_load_arbiter_if #(
   parameter int N = 8
);
   logic                  hold;
   logic [3:0]            req;
   logic [3:0][1:0]       dest;
   logic [3:0][N-1:0]     data;
   logic [N-1:0]          bus_data;
   logic [3:0]            load_en;
   logic [3:0]            ack;
   logic [1:0]            grant_id;
   logic                  busy;

   modport master (
      output hold, req, dest, data,
      input  bus_data, load_en, ack, grant_id, busy
   );

   modport slave (
      input  hold, req, dest, data,
      output bus_data, load_en, ack, grant_id, busy
   );
endinterface

// File: rtl/register_load_arbiter.sv
// register_load_arbiter
//   Four requesters compete for one shared register-load bus. A round-robin
//   search starting at pointer p picks a winner in IDLE; on the next edge the
//   winner's payload, target index and id are captured and a single LOAD
//   cycle strobes the target register and acknowledges the requester.
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous active-low reset, clears all state
//     bus    - register_load_arbiter_if.slave (request inputs, bus outputs)
module register_load_arbiter #(
   parameter int N = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   register_load_arbiter_if.slave     bus
);

   typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

   state_t        state, state_nxt;
   logic [1:0]    ptr;
   logic [1:0]    win;
   logic          found;
   logic          grant_go;
   logic [1:0]    idx;

   logic [N-1:0]  bus_data_q;
   logic [3:0]    load_en_q;
   logic [3:0]    ack_q;
   logic [1:0]    grant_id_q;
   logic          busy_q;

   // Round-robin search: p, p+1, ... mod 4; the 2-bit add wraps naturally.
   always_comb begin
      found = 1'b0;
      win   = 2'd0;
      idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_go  = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.hold && found) begin
               state_nxt = LOAD;
               grant_go  = 1'b1;
            end
         end
         LOAD: state_nxt = IDLE;   // single-cycle transfer, hold/req ignored
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Everything the transfer needs is captured on the grant edge, so request
   // changes during LOAD cannot disturb it. Strobes are cleared on the next
   // edge (LOAD never grants), and the async reset drops them mid-LOAD.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr        <= 2'd0;
         bus_data_q <= '0;
         grant_id_q <= 2'd0;
         load_en_q  <= 4'd0;
         ack_q      <= 4'd0;
         busy_q     <= 1'b0;
      end else if (grant_go) begin
         ptr        <= win + 2'd1;
         bus_data_q <= bus.data[win];
         grant_id_q <= win;
         load_en_q  <= 4'b0001 << bus.dest[win];
         ack_q      <= 4'b0001 << win;
         busy_q     <= 1'b1;
      end else begin
         load_en_q  <= 4'd0;
         ack_q      <= 4'd0;
         busy_q     <= 1'b0;
      end
   end

   assign bus.bus_data = bus_data_q;
   assign bus.load_en  = load_en_q;
   assign bus.ack      = ack_q;
   assign bus.grant_id = grant_id_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_register_load_arbiter.sv
module tb_register_load_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   register_load_arbiter_if #(.N(8)) bus ();

   register_load_arbiter #(.N(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic nedge();
      @(negedge clk);
   endtask

   // One granted cycle followed by the return to IDLE; requester drops req
   // while ack is high.
   task automatic xfer(input string tag, input int id, input logic [1:0] dst,
                       input logic [7:0] dat);
      logic [3:0] oh;
      logic [3:0] le;
      oh = 4'b0001 << id;
      le = 4'b0001 << dst;
      nedge();
      chk({tag, "_ack"},   32'(bus.ack), 32'(oh));
      chk({tag, "_gid"},   32'(bus.grant_id), 32'(id));
      chk({tag, "_ld"},    32'(bus.load_en), 32'(le));
      chk({tag, "_data"},  32'(bus.bus_data), 32'(dat));
      chk({tag, "_busy"},  32'(bus.busy), 32'd1);
      bus.req = bus.req & ~oh;
      nedge();
      chk({tag, "_idle"},  32'(bus.busy), 32'd0);
      chk({tag, "_noack"}, 32'(bus.ack), 32'd0);
   endtask

   initial begin
      bus.hold = 1'b0;
      bus.req  = 4'd0;
      bus.dest = '0;
      bus.data = '0;

      // reset state
      #12;
      chk("rst_ld",   32'(bus.load_en), 32'd0);
      chk("rst_ack",  32'(bus.ack), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_data", 32'(bus.bus_data), 32'd0);
      chk("rst_gid",  32'(bus.grant_id), 32'd0);
      nedge();
      reset = 1'b1;

      // idle with no requests
      nedge();
      chk("noreq_busy", 32'(bus.busy), 32'd0);

      // single request, dest 2, data A5 (p -> 1)
      bus.req = 4'b0001; bus.dest[0] = 2'd2; bus.data[0] = 8'hA5;
      xfer("single", 0, 2'd2, 8'hA5);
      chk("single_hold_data", 32'(bus.bus_data), 32'hA5);
      chk("single_hold_gid",  32'(bus.grant_id), 32'd0);

      // in-flight stability: data changes during LOAD (p=1 -> winner 0, p -> 1)
      bus.req = 4'b0001; bus.dest[0] = 2'd1; bus.data[0] = 8'h11;
      nedge();
      chk("stab_ld", 32'(bus.load_en), 32'h2);
      bus.data[0] = 8'hFF; bus.dest[0] = 2'd3; bus.req = 4'd0;
      nedge();
      chk("stab_data", 32'(bus.bus_data), 32'h11);

      // reset mid-LOAD: strobes drop without an edge
      bus.req = 4'b0100; bus.dest[2] = 2'd3; bus.data[2] = 8'h5C;
      nedge();
      chk("rml_ack", 32'(bus.ack), 32'h4);
      bus.req = 4'd0;
      #2 reset = 1'b0;
      #1;
      chk("rml_ld0",   32'(bus.load_en), 32'd0);
      chk("rml_ack0",  32'(bus.ack), 32'd0);
      chk("rml_busy0", 32'(bus.busy), 32'd0);
      nedge();
      reset = 1'b1;
      nedge();
      chk("rml_after_ack",  32'(bus.ack), 32'd0);
      chk("rml_after_data", 32'(bus.bus_data), 32'd0);

      // fairness from p=0: order 0,1,2,3, one transfer per two cycles
      for (int i = 0; i < 4; i++) begin
         bus.dest[i] = 2'(3 - i);
         bus.data[i] = 8'(8'h10 + i);
      end
      bus.req = 4'b1111;
      for (int i = 0; i < 4; i++)
         xfer($sformatf("fair%0d", i), i, 2'(3 - i), 8'(8'h10 + i));

      // pointer wrap: drive p to 3, then req=1001 -> 3 then 0, p -> 1
      bus.req = 4'b0100;
      xfer("wrap_pre", 2, 2'd1, 8'h12);
      bus.req = 4'b1001;
      xfer("wrap_3", 3, 2'd0, 8'h13);
      xfer("wrap_0", 0, 2'd3, 8'h10);
      bus.req = 4'b0011;
      xfer("wrap_p1", 1, 2'd2, 8'h11);

      // hold blocks grants for 5 cycles, then grant one cycle after release
      bus.hold = 1'b1; bus.req = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         nedge();
         chk($sformatf("hold%0d_ack", i),  32'(bus.ack), 32'd0);
         chk($sformatf("hold%0d_busy", i), 32'(bus.busy), 32'd0);
      end
      bus.hold = 1'b0;
      xfer("hold_rel", 1, 2'd2, 8'h11);

      // same dest from two requesters; p=2 -> 0 then 1, last write wins
      bus.dest[0] = 2'd2; bus.data[0] = 8'h33;
      bus.dest[1] = 2'd2; bus.data[1] = 8'h44;
      bus.req = 4'b0011;
      xfer("same_0", 0, 2'd2, 8'h33);
      xfer("same_1", 1, 2'd2, 8'h44);
      chk("same_last", 32'(bus.bus_data), 32'h44);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
